// File: rtl/decode_hazard_stage.sv
// Decode stage: register file with write-back bypass, {Z,V,N} flag register, in-decode B/BR
// resolution, load-use / branch hazard bubbles, sticky halt and the registered ID/EX bundle.
module decode_hazard_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int FLAG_FWD = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_valid_i,
  input  logic [15:0]       if_instr_i,
  input  logic [DATA_W-1:0] if_pc_plus2_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              exm_we_i,
  input  logic [REG_AW-1:0] exm_reg_i,
  input  logic [2:0]        ex_flag_we_i,
  input  logic [2:0]        ex_flags_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] branch_target_o,
  output logic              halt_pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              de_valid_o,
  output logic [DATA_W-1:0] de_rs_data_o,
  output logic [DATA_W-1:0] de_rt_data_o,
  output logic [DATA_W-1:0] de_imm_o,
  output logic [REG_AW-1:0] de_rs_o,
  output logic [REG_AW-1:0] de_rt_o,
  output logic [REG_AW-1:0] de_rd_o,
  output logic [3:0]        de_aluop_o,
  output logic              de_alusrc_o,
  output logic              de_memtoreg_o,
  output logic              de_regwrite_o,
  output logic              de_memwrite_o,
  output logic              de_memread_o,
  output logic              de_flag_en_o,
  output logic              de_halt_o
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [2:0]        flag_q;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              de_valid_q, de_valid_d;
  logic [DATA_W-1:0] de_rs_data_q, de_rs_data_d;
  logic [DATA_W-1:0] de_rt_data_q, de_rt_data_d;
  logic [DATA_W-1:0] de_imm_q, de_imm_d;
  logic [REG_AW-1:0] de_rs_q, de_rs_d;
  logic [REG_AW-1:0] de_rt_q, de_rt_d;
  logic [REG_AW-1:0] de_rd_q, de_rd_d;
  logic [3:0]        de_aluop_q, de_aluop_d;
  logic              de_alusrc_q, de_alusrc_d;
  logic              de_memtoreg_q, de_memtoreg_d;
  logic              de_regwrite_q, de_regwrite_d;
  logic              de_memwrite_q, de_memwrite_d;
  logic              de_memread_q, de_memread_d;
  logic              de_flag_en_q, de_flag_en_d;
  logic              de_halt_q, de_halt_d;

  logic [3:0]        op;
  logic              is_alu, is_shift, is_ldst, is_llhb, is_b, is_br, is_pcs, is_hlt;
  logic [REG_AW-1:0] rs_a, rt_a, rd_a;
  logic              rs_used, rt_used;
  logic [DATA_W-1:0] rs_val, rt_val, imm, b_off, target;
  logic [2:0]        flag_eff;
  logic              fz, fv, fn, cond_true, taken;
  logic              active, haz_load_use, haz_br_dep, haz_flag, stall, flush;

  assign op       = if_instr_i[15:12];
  assign is_alu   = ~op[3];
  assign is_shift = (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
  assign is_ldst  = (op == OP_LW) || (op == OP_SW);
  assign is_llhb  = (op == OP_LLB) || (op == OP_LHB);
  assign is_b     = (op == OP_B);
  assign is_br    = (op == OP_BR);
  assign is_pcs   = (op == OP_PCS);
  assign is_hlt   = (op == OP_HLT);

  assign rs_a = is_llhb ? REG_AW'(if_instr_i[11:8]) : REG_AW'(if_instr_i[7:4]);
  assign rt_a = is_ldst ? REG_AW'(if_instr_i[11:8]) : REG_AW'(if_instr_i[3:0]);
  assign rd_a = REG_AW'(if_instr_i[11:8]);

  assign rs_used = (op <= OP_LHB) || is_br;
  assign rt_used = (op <= 4'h3) || (op == 4'h7) || (op == OP_SW);

  // Same-cycle write-back is visible to the read; r0 is hard-wired to zero.
  always_comb begin
    rs_val = '0;
    if (rs_a != '0) rs_val = (wb_we_i && (wb_reg_i == rs_a)) ? wb_data_i : rf_q[rs_a];
  end

  always_comb begin
    rt_val = '0;
    if (rt_a != '0) rt_val = (wb_we_i && (wb_reg_i == rt_a)) ? wb_data_i : rf_q[rt_a];
  end

  always_comb begin
    imm = '0;
    if (is_shift)     imm = DATA_W'(if_instr_i[3:0]);
    else if (is_ldst) imm = DATA_W'($signed(if_instr_i[3:0])) << 1;
    else if (is_llhb) imm = DATA_W'(if_instr_i[7:0]);
  end

  assign flag_eff = (FLAG_FWD != 0) ? ((flag_q & ~ex_flag_we_i) | (ex_flags_i & ex_flag_we_i))
                                    : flag_q;
  assign fz = flag_eff[2];
  assign fv = flag_eff[1];
  assign fn = flag_eff[0];

  always_comb begin
    cond_true = 1'b0;
    case (if_instr_i[11:9])
      3'b000:  cond_true = ~fz;
      3'b001:  cond_true = fz;
      3'b010:  cond_true = ~fz & ~fn;
      3'b011:  cond_true = fn;
      3'b100:  cond_true = fz | (~fz & ~fn);
      3'b101:  cond_true = fn | fz;
      3'b110:  cond_true = fv;
      default: cond_true = 1'b1;
    endcase
  end

  assign b_off  = DATA_W'($signed(if_instr_i[8:0])) << 1;
  assign target = is_br ? rs_val : (if_pc_plus2_i + b_off);
  assign taken  = (is_b || is_br) && cond_true;

  assign active = if_valid_i && !halt_q;

  assign haz_load_use = de_valid_q && de_memread_q && (de_rd_q != '0) &&
                        ((rs_used && (de_rd_q == rs_a)) || (rt_used && (de_rd_q == rt_a)));
  // BR holds until its source leaves EX/MEM, after which the write-back bypass supplies it.
  assign haz_br_dep   = is_br && (rs_a != '0) &&
                        ((de_valid_q && de_regwrite_q && (de_rd_q == rs_a)) ||
                         (exm_we_i && (exm_reg_i == rs_a)));
  assign haz_flag     = (FLAG_FWD == 0) && (is_b || is_br) && de_valid_q && de_flag_en_q;

  assign stall = active && (haz_load_use || haz_br_dep || haz_flag);
  assign flush = active && taken && !stall;

  always_comb begin
    de_valid_d    = 1'b0;
    de_rs_data_d  = '0;
    de_rt_data_d  = '0;
    de_imm_d      = '0;
    de_rs_d       = '0;
    de_rt_d       = '0;
    de_rd_d       = '0;
    de_aluop_d    = '0;
    de_alusrc_d   = 1'b0;
    de_memtoreg_d = 1'b0;
    de_regwrite_d = 1'b0;
    de_memwrite_d = 1'b0;
    de_memread_d  = 1'b0;
    de_flag_en_d  = 1'b0;
    de_halt_d     = 1'b0;
    if (active && !stall) begin
      de_valid_d    = 1'b1;
      de_rs_data_d  = is_pcs ? if_pc_plus2_i : rs_val;
      de_rt_data_d  = rt_val;
      de_imm_d      = imm;
      de_rs_d       = rs_a;
      de_rt_d       = rt_a;
      de_rd_d       = rd_a;
      de_aluop_d    = op;
      de_alusrc_d   = is_shift || is_ldst || is_llhb;
      de_memtoreg_d = (op == OP_LW);
      de_regwrite_d = is_alu || (op == OP_LW) || is_llhb || is_pcs;
      de_memwrite_d = (op == OP_SW);
      de_memread_d  = (op == OP_LW);
      // RED (0011) and PADDSB (0111) leave the flags alone.
      de_flag_en_d  = is_alu && (op != 4'h3) && (op != 4'h7);
      de_halt_d     = is_hlt;
    end
  end

  assign halt_d      = halt_q || (active && !stall && is_hlt);
  assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      flag_q        <= '0;
      halt_q        <= 1'b0;
      stall_cnt_q   <= '0;
      de_valid_q    <= 1'b0;
      de_rs_data_q  <= '0;
      de_rt_data_q  <= '0;
      de_imm_q      <= '0;
      de_rs_q       <= '0;
      de_rt_q       <= '0;
      de_rd_q       <= '0;
      de_aluop_q    <= '0;
      de_alusrc_q   <= 1'b0;
      de_memtoreg_q <= 1'b0;
      de_regwrite_q <= 1'b0;
      de_memwrite_q <= 1'b0;
      de_memread_q  <= 1'b0;
      de_flag_en_q  <= 1'b0;
      de_halt_q     <= 1'b0;
    end else begin
      if (wb_we_i && (wb_reg_i != '0)) rf_q[wb_reg_i] <= wb_data_i;
      flag_q        <= (flag_q & ~ex_flag_we_i) | (ex_flags_i & ex_flag_we_i);
      halt_q        <= halt_d;
      stall_cnt_q   <= stall_cnt_d;
      de_valid_q    <= de_valid_d;
      de_rs_data_q  <= de_rs_data_d;
      de_rt_data_q  <= de_rt_data_d;
      de_imm_q      <= de_imm_d;
      de_rs_q       <= de_rs_d;
      de_rt_q       <= de_rt_d;
      de_rd_q       <= de_rd_d;
      de_aluop_q    <= de_aluop_d;
      de_alusrc_q   <= de_alusrc_d;
      de_memtoreg_q <= de_memtoreg_d;
      de_regwrite_q <= de_regwrite_d;
      de_memwrite_q <= de_memwrite_d;
      de_memread_q  <= de_memread_d;
      de_flag_en_q  <= de_flag_en_d;
      de_halt_q     <= de_halt_d;
    end
  end

  assign stall_o         = stall;
  assign flush_o         = flush;
  assign branch_target_o = target;
  assign halt_pc_o       = halt_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign de_valid_o      = de_valid_q;
  assign de_rs_data_o    = de_rs_data_q;
  assign de_rt_data_o    = de_rt_data_q;
  assign de_imm_o        = de_imm_q;
  assign de_rs_o         = de_rs_q;
  assign de_rt_o         = de_rt_q;
  assign de_rd_o         = de_rd_q;
  assign de_aluop_o      = de_aluop_q;
  assign de_alusrc_o     = de_alusrc_q;
  assign de_memtoreg_o   = de_memtoreg_q;
  assign de_regwrite_o   = de_regwrite_q;
  assign de_memwrite_o   = de_memwrite_q;
  assign de_memread_o    = de_memread_q;
  assign de_flag_en_o    = de_flag_en_q;
  assign de_halt_o       = de_halt_q;
endmodule

// File: tb/tb_decode_hazard_stage.sv
// Drives a flag-forwarding and a flag-stalling instance with identical stimulus and checks both
// against a reference model through a per-cycle expectation queue.
module tb_decode_hazard_stage;
  typedef struct packed {
    bit        vld;
    bit [15:0] rsd, rtd, imm;
    bit [3:0]  rs, rt, rd, aluop;
    bit        alusrc, memtoreg, regwrite, memwrite, memread, flag_en, halt;
  } de_t;

  typedef struct packed {
    bit              chk;
    bit              halt;
    de_t [1:0]       de;
    bit [1:0]        st, fl;
    bit [1:0][15:0]  tg, cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, wb_we, exm_we;
  logic [15:0] if_instr, if_pc2, wb_data;
  logic [3:0]  wb_reg, exm_reg;
  logic [2:0]  fl_we, fl_val;

  wire [1:0]       st, fl, hl, d_vld, d_als, d_m2r, d_rw, d_mw, d_mr, d_fe, d_hlt;
  wire [1:0][15:0] tg, cn, d_rsd, d_rtd, d_imm;
  wire [1:0][3:0]  d_rs, d_rt, d_rd, d_aop;

  always #5 clk = ~clk;

  decode_hazard_stage #(.DATA_W(16), .REG_AW(4), .FLAG_FWD(1), .CNT_W(16)) u_fwd (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_plus2_i(if_pc2),
    .wb_we_i(wb_we), .wb_reg_i(wb_reg), .wb_data_i(wb_data), .exm_we_i(exm_we), .exm_reg_i(exm_reg),
    .ex_flag_we_i(fl_we), .ex_flags_i(fl_val), .stall_o(st[1]), .flush_o(fl[1]),
    .branch_target_o(tg[1]), .halt_pc_o(hl[1]), .stall_cnt_o(cn[1]), .de_valid_o(d_vld[1]),
    .de_rs_data_o(d_rsd[1]), .de_rt_data_o(d_rtd[1]), .de_imm_o(d_imm[1]), .de_rs_o(d_rs[1]),
    .de_rt_o(d_rt[1]), .de_rd_o(d_rd[1]), .de_aluop_o(d_aop[1]), .de_alusrc_o(d_als[1]),
    .de_memtoreg_o(d_m2r[1]), .de_regwrite_o(d_rw[1]), .de_memwrite_o(d_mw[1]),
    .de_memread_o(d_mr[1]), .de_flag_en_o(d_fe[1]), .de_halt_o(d_hlt[1]));

  decode_hazard_stage #(.DATA_W(16), .REG_AW(4), .FLAG_FWD(0), .CNT_W(16)) u_stl (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_plus2_i(if_pc2),
    .wb_we_i(wb_we), .wb_reg_i(wb_reg), .wb_data_i(wb_data), .exm_we_i(exm_we), .exm_reg_i(exm_reg),
    .ex_flag_we_i(fl_we), .ex_flags_i(fl_val), .stall_o(st[0]), .flush_o(fl[0]),
    .branch_target_o(tg[0]), .halt_pc_o(hl[0]), .stall_cnt_o(cn[0]), .de_valid_o(d_vld[0]),
    .de_rs_data_o(d_rsd[0]), .de_rt_data_o(d_rtd[0]), .de_imm_o(d_imm[0]), .de_rs_o(d_rs[0]),
    .de_rt_o(d_rt[0]), .de_rd_o(d_rd[0]), .de_aluop_o(d_aop[0]), .de_alusrc_o(d_als[0]),
    .de_memtoreg_o(d_m2r[0]), .de_regwrite_o(d_rw[0]), .de_memwrite_o(d_mw[0]),
    .de_memread_o(d_mr[0]), .de_flag_en_o(d_fe[0]), .de_halt_o(d_hlt[0]));

  bit [15:0] m_regs [16];
  bit [2:0]  m_fl;
  bit        m_halt;
  de_t       m_de [2];
  bit [15:0] m_cnt [2];
  bit        armed;
  exp_t      sbq [$];
  int        n_vec = 0;
  int        n_err = 0;

  function automatic bit [15:0] m_read(bit [3:0] a, bit we, bit [3:0] wr, bit [15:0] wd);
    if (a == 0) return 16'h0;
    if (we && wr == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit cond_ok(bit [2:0] c, bit [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return z == 0;
      3'd1: return z == 1;
      3'd2: return z == 0 && n == 0;
      3'd3: return n == 1;
      3'd4: return z == 1 || (z == 0 && n == 0);
      3'd5: return n == 1 || z == 1;
      3'd6: return v == 1;
      default: return 1'b1;
    endcase
  endfunction

  // One cycle: drive inputs, queue what both DUTs must show this cycle, then advance the model.
  task automatic step(input bit r, input bit v, input bit [15:0] ins, input bit [15:0] pc2,
                      input bit wbe, input bit [3:0] wbr, input bit [15:0] wbd,
                      input bit exw, input bit [3:0] exr, input bit [2:0] fwe, input bit [2:0] fvl);
    exp_t e;
    de_t dec;
    de_t nd [2];
    bit [15:0] nc [2];
    bit [3:0] op, rsa, rta;
    bit [15:0] rsv, rtv;
    bit [2:0] eff;
    bit act, uses_rs, uses_rt, lu, brd, fh, stl, isbr;
    int off;
    rst = r; if_valid = v; if_instr = ins; if_pc2 = pc2;
    wb_we = wbe; wb_reg = wbr; wb_data = wbd; exm_we = exw; exm_reg = exr;
    fl_we = fwe; fl_val = fvl;

    op  = ins[15:12];
    rsa = (op == 10 || op == 11) ? ins[11:8] : ins[7:4];
    rta = (op == 8 || op == 9) ? ins[11:8] : ins[3:0];
    rsv = m_read(rsa, wbe, wbr, wbd);
    rtv = m_read(rta, wbe, wbr, wbd);
    uses_rs = (op <= 11) || (op == 13);
    uses_rt = (op <= 3) || (op == 7) || (op == 9);
    isbr = (op == 12) || (op == 13);
    act = v && !m_halt;
    off = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);

    dec = '0;
    dec.vld = 1; dec.rs = rsa; dec.rt = rta; dec.rd = ins[11:8]; dec.aluop = op;
    dec.rsd = (op == 14) ? pc2 : rsv;
    dec.rtd = rtv;
    if (op >= 4 && op <= 6) dec.imm = {12'h0, ins[3:0]};
    else if (op == 8 || op == 9)
      dec.imm = 16'(2 * (ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0])));
    else if (op == 10 || op == 11) dec.imm = {8'h0, ins[7:0]};
    dec.alusrc   = (op >= 4 && op <= 6) || (op >= 8 && op <= 11);
    dec.memtoreg = (op == 8);
    dec.regwrite = (op <= 8) || op == 10 || op == 11 || op == 14;
    dec.memwrite = (op == 9);
    dec.memread  = (op == 8);
    dec.flag_en  = op inside {0, 1, 2, 4, 5, 6};
    dec.halt     = (op == 15);

    e = '0;
    e.chk = armed && !r;
    e.halt = m_halt;
    for (int i = 0; i < 2; i++) begin
      e.de[i] = m_de[i];
      e.cnt[i] = m_cnt[i];
      for (int b = 0; b < 3; b++) eff[b] = (i == 1 && fwe[b]) ? fvl[b] : m_fl[b];
      lu  = m_de[i].vld && m_de[i].memread && m_de[i].rd != 0 &&
            ((uses_rs && m_de[i].rd == rsa) || (uses_rt && m_de[i].rd == rta));
      brd = op == 13 && rsa != 0 &&
            ((m_de[i].vld && m_de[i].regwrite && m_de[i].rd == rsa) || (exw && exr == rsa));
      fh  = i == 0 && isbr && m_de[i].vld && m_de[i].flag_en;
      stl = act && (lu || brd || fh);
      e.st[i] = stl;
      e.fl[i] = act && isbr && cond_ok(ins[11:9], eff) && !stl;
      e.tg[i] = (op == 13) ? rsv : 16'(int'(pc2) + 2 * off);
      nd[i] = (act && !stl) ? dec : '0;
      nc[i] = (stl && m_cnt[i] != 16'hFFFF) ? m_cnt[i] + 16'd1 : m_cnt[i];
    end
    sbq.push_back(e);

    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 16; k++) m_regs[k] = 0;
      m_fl = 0; m_halt = 0; armed = 1;
      for (int i = 0; i < 2; i++) begin m_de[i] = '0; m_cnt[i] = 0; end
    end else begin
      if (wbe && wbr != 0) m_regs[wbr] = wbd;
      for (int b = 0; b < 3; b++) if (fwe[b]) m_fl[b] = fvl[b];
      m_halt = m_halt || (act && op == 15);
      for (int i = 0; i < 2; i++) begin m_de[i] = nd[i]; m_cnt[i] = nc[i]; end
    end
    #1;
  endtask

  task automatic issue(input bit [15:0] ins, input bit [15:0] pc2);
    step(0, 1, ins, pc2, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wbw(input bit [3:0] r, input bit [15:0] d);
    step(0, 0, 0, 0, 1, r, d, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 16'h0312, 0, 1, 3, 16'h1234, 1, 3, 3'b111, 3'b111);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit [3:0] nib();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
  endfunction

  task automatic rnd_step();
    bit [3:0] op;
    op = 4'($urandom_range(0, 14));
    if ($urandom_range(0, 299) == 0) op = 4'hF;
    step(0, $urandom_range(0, 99) < 85, {op, nib(), nib(), nib()}, 16'($urandom) & 16'hFFFE,
         $urandom_range(0, 1) == 1, nib(), 16'($urandom),
         $urandom_range(0, 9) < 3, nib(), 3'($urandom), 3'($urandom));
  endtask

  task automatic cmp(input string nm, input logic [79:0] got, input logic [79:0] want);
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    de_t g;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          n_vec++;
          for (int i = 0; i < 2; i++) begin
            g = {d_vld[i], d_rsd[i], d_rtd[i], d_imm[i], d_rs[i], d_rt[i], d_rd[i], d_aop[i],
                 d_als[i], d_m2r[i], d_rw[i], d_mw[i], d_mr[i], d_fe[i], d_hlt[i]};
            cmp($sformatf("de_bundle[fwd=%0d]", i), 80'(g), 80'(e.de[i]));
            cmp($sformatf("stall[fwd=%0d]", i), 80'(st[i]), 80'(e.st[i]));
            cmp($sformatf("flush[fwd=%0d]", i), 80'(fl[i]), 80'(e.fl[i]));
            if (e.fl[i]) cmp($sformatf("branch_target[fwd=%0d]", i), 80'(tg[i]), 80'(e.tg[i]));
            cmp($sformatf("stall_cnt[fwd=%0d]", i), 80'(cn[i]), 80'(e.cnt[i]));
            cmp($sformatf("halt_pc[fwd=%0d]", i), 80'(hl[i]), 80'(e.halt));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    @(posedge clk);
    #1;
    do_reset();
    // ADD r3,r1,r2 with preloaded operands
    wbw(1, 16'd5);
    wbw(2, 16'd7);
    issue(16'h0312, 16'h0002);
    idle();
    // LW r4 then dependent ADD r5,r4,r1 (held in IF/ID during the stall)
    issue(16'h8410, 16'h0004);
    issue(16'h0541, 16'h0006);
    issue(16'h0541, 16'h0006);
    idle();
    // SUB writes Z=1 in EX while B EQ +4 decodes, then the same B with flags committed
    issue(16'h1711, 16'h000E);
    step(0, 1, 16'hC204, 16'h0010, 0, 0, 0, 0, 0, 3'b111, 3'b100);
    step(0, 1, 16'hC204, 16'h0010, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    idle();
    // LLB r6 then BR always r6: producer in ID/EX, then in EX/MEM, then written back
    issue(16'hA640, 16'h0020);
    issue(16'hDE60, 16'h0022);
    step(0, 1, 16'hDE60, 16'h0022, 0, 0, 0, 1, 6, 0, 0);
    step(0, 1, 16'hDE60, 16'h0022, 1, 6, 16'h0040, 0, 0, 0, 0);
    idle();
    // write to r0 is ignored
    wbw(0, 16'hBEEF);
    issue(16'h0700, 16'h0030);
    step(0, 1, 16'h0700, 16'h0032, 1, 0, 16'hBEEF, 0, 0, 0, 0);
    // sticky halt, then reset clears it
    issue(16'hF000, 16'h0040);
    issue(16'h0312, 16'h0042);
    issue(16'hC3FF, 16'h0044);
    issue(16'h8410, 16'h0046);
    do_reset();
    issue(16'h0312, 16'h0002);
    idle();
    for (int ph = 0; ph < 8; ph++) begin
      do_reset();
      for (int k = 0; k < 200; k++) rnd_step();
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
